// File: rtl/square_64b_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// square_64b_arbiter
//
// Shares one combinational 64-bit squarer among NREQ requesters. An arbiter
// picks one operand per cycle. The operand goes into stage S1, passes through
// the squarer, and lands in stage S2. S2 drives the tagged 128-bit response.
//
// Configuration macro: SQUARE_ARB_RR_EN
//   defined   -> round-robin arbitration; a 'last' pointer starts the search at
//                last+1 and wraps.
//   undefined -> fixed priority; the lowest asserted index always wins, and
//                there is no 'last' register.
//
// Ports:
//   clk, rst   : clock; synchronous active-high reset
//   req_valid  : [NREQ]      per-requester operand valid
//   req_data   : [NREQ*64]   operand i at bits [64i+63:64i]
//   req_ready  : [NREQ]      one-hot (or zero) accept
//   rsp_valid  : S2 holds a result
//   rsp_ready  : consumer accepts the result
//   rsp_data   : [128]       unsigned square of the operand
//   rsp_id     : [IDW]       requester index that supplied the operand
//   busy       : either pipeline stage is occupied
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both high. A producer may change or drop an
// unaccepted request at any time. rsp_data and rsp_id stay stable while
// rsp_valid is high and rsp_ready is low. req_ready depends combinationally
// on rsp_ready, but rsp_data and rsp_id come straight from registers.
// -----------------------------------------------------------------------------

// Purely combinational full-width unsigned squarer.
module square_64b (
    input  logic [63:0]  op,
    output logic [127:0] sq
);
    assign sq = {64'd0, op} * {64'd0, op};
endmodule

module square_64b_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*64-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [127:0]         rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);

    // Stage S1: operand register
    logic           s1_v_q, s1_v_d;
    logic [63:0]    s1_op_q, s1_op_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;

    // Stage S2: result register
    logic           s2_v_q, s2_v_d;
    logic [127:0]   s2_res_q, s2_res_d;
    logic [IDW-1:0] s2_id_q, s2_id_d;

`ifdef SQUARE_ARB_RR_EN
    logic [IDW-1:0] last_q, last_d;
`endif

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic [63:0]     grant_op;
    logic            found;
    logic            s2_load;
    logic            s1_free;
    logic            hs;
    logic [127:0]    sq;

    square_64b u_square (
        .op (s1_op_q),
        .sq (sq)
    );

    // Arbiter. In round-robin mode the first pass only considers indices
    // above 'last'. The second pass considers all indices, so it only matters
    // when the first pass found nothing, and that gives the wrap back to 0.
    always_comb begin : arbiter
        grant    = '0;
        grant_id = '0;
        grant_op = '0;
        found    = 1'b0;
`ifdef SQUARE_ARB_RR_EN
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && (IDW'(i) > last_q)) begin
                grant[i] = 1'b1;
                grant_id = IDW'(i);
                grant_op = req_data[i*64 +: 64];
                found    = 1'b1;
            end
        end
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i]) begin
                grant[i] = 1'b1;
                grant_id = IDW'(i);
                grant_op = req_data[i*64 +: 64];
                found    = 1'b1;
            end
        end
    end

    // S2 can take S1's value when it is empty or is being popped this cycle.
    // S1 can refill in that same cycle, so a pop and a fill need no bubble.
    assign s2_load   = s1_v_q & (~s2_v_q | rsp_ready);
    assign s1_free   = ~s1_v_q | s2_load;
    assign req_ready = grant & {NREQ{s1_free}};
    assign hs        = |(req_valid & req_ready);

    always_comb begin : next_state
        s1_v_d   = s1_v_q;
        s1_op_d  = s1_op_q;
        s1_id_d  = s1_id_q;
        s2_v_d   = s2_v_q;
        s2_res_d = s2_res_q;
        s2_id_d  = s2_id_q;
`ifdef SQUARE_ARB_RR_EN
        last_d   = last_q;
`endif
        if (hs) begin
            s1_v_d  = 1'b1;
            s1_op_d = grant_op;
            s1_id_d = grant_id;
`ifdef SQUARE_ARB_RR_EN
            last_d  = grant_id;
`endif
        end else if (s2_load) begin
            s1_v_d = 1'b0;
        end

        if (s2_load) begin
            s2_v_d   = 1'b1;
            s2_res_d = sq;
            s2_id_d  = s1_id_q;
        end else if (rsp_ready) begin
            s2_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_op_q  <= '0;
            s1_id_q  <= '0;
            s2_v_q   <= 1'b0;
            s2_res_q <= '0;
            s2_id_q  <= '0;
`ifdef SQUARE_ARB_RR_EN
            // Start the pointer on the last index so requester 0 goes first.
            last_q   <= IDW'(NREQ - 1);
`endif
        end else begin
            s1_v_q   <= s1_v_d;
            s1_op_q  <= s1_op_d;
            s1_id_q  <= s1_id_d;
            s2_v_q   <= s2_v_d;
            s2_res_q <= s2_res_d;
            s2_id_q  <= s2_id_d;
`ifdef SQUARE_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    assign rsp_valid = s2_v_q;
    assign rsp_data  = s2_res_q;
    assign rsp_id    = s2_id_q;
    assign busy      = s1_v_q | s2_v_q;

endmodule

// File: tb/tb_square_64b_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for square_64b_arbiter. It uses directed sequences, a
// vector table for the squarer arithmetic, and a randomized phase. The
// randomized phase is checked against a model of a two-entry in-order buffer
// that is fed by the arbitration rule.
module tb_square_64b_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = 128 + IDW;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*64-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [127:0]       rsp_data;
    logic [IDW-1:0]     rsp_id;
    logic               busy;

    square_64b_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got hang expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    int           edge_q[$];
    int           m_last;

    typedef struct {
        logic [IDW-1:0] id;
        logic [63:0]    op;
        logic [127:0]   sq;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [127:0] sq64(input logic [63:0] a);
        logic [127:0] x;
        x = {64'd0, a};
        return x * x;
    endfunction

    // The arbitration rule, stated directly: scan from the start index and take
    // the first valid requester.
    function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] v, input int last);
        logic [NREQ-1:0] r;
        int idx;
        r = '0;
        for (int k = 1; k <= NREQ; k++) begin
`ifdef SQUARE_ARB_RR_EN
            idx = (last + k) % NREQ;
`else
            idx = k - 1;
`endif
            if (v[idx] && r == '0) r[idx] = 1'b1;
        end
        return r;
    endfunction

    function automatic int oh2id(input logic [NREQ-1:0] g);
        int r;
        r = 0;
        for (int i = 0; i < NREQ; i++) if (g[i]) r = i;
        return r;
    endfunction

    // ---------------- main stimulus ----------------
    initial begin
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] exp_g;
        logic [127:0]    held;
        logic [63:0]     op;
        logic [W-1:0]    e;
        int id, got, acc, n;
        logic exp_free, exp_rv;

        vecs[0] = '{2'd0, 64'd0,                  128'd0};
        vecs[1] = '{2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
        vecs[2] = '{2'd2, 64'd1,                  128'd1};
        vecs[3] = '{2'd3, 64'h1_0000_0000,        128'h1_0000_0000_0000_0000};
        vecs[4] = '{2'd0, 64'hFFFF_FFFF,          128'hFFFF_FFFE_0000_0001};
        vecs[5] = '{2'd1, 64'd12345,              128'd152399025};
        vecs[6] = '{2'd2, 64'h8000_0000_0000_0000, 128'h4000_0000_0000_0000_0000_0000_0000_0000};
        vecs[7] = '{2'd3, 64'h1_0000_0001,        128'h1_0000_0002_0000_0001};

        rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
        do_reset();

        // Reset state
        @(negedge clk);
        check("reset_rsp_valid", 128'(rsp_valid), 128'd0);
        check("reset_rsp_data",  rsp_data,        128'd0);
        check("reset_rsp_id",    128'(rsp_id),    128'd0);
        check("reset_busy",      128'(busy),      128'd0);
        check("reset_req_ready", 128'(req_ready), 128'd0);
        tick();

        // Single request: requester 2 sends 3
        req_valid = 4'b0100; req_data[2*64 +: 64] = 64'd3;
        @(negedge clk); check("single_grant", 128'(req_ready), 128'(4'b0100));
        tick(); req_valid = '0;
        @(negedge clk);
        check("single_busy_s1", 128'(busy), 128'd1);
        check("single_not_yet", 128'(rsp_valid), 128'd0);
        tick();
        @(negedge clk);
        check("single_valid", 128'(rsp_valid), 128'd1);
        check("single_data",  rsp_data, 128'd9);
        check("single_id",    128'(rsp_id), 128'd2);
        check("single_busy_s2", 128'(busy), 128'd1);
        tick();
        @(negedge clk);
        check("single_done_valid", 128'(rsp_valid), 128'd0);
        check("single_done_busy",  128'(busy), 128'd0);
        tick();

        // Arithmetic vector table
        for (int t = 0; t < 8; t++) begin
            id = int'(vecs[t].id);
            req_valid = '0; req_valid[id] = 1'b1;
            req_data[id*64 +: 64] = vecs[t].op;
            @(negedge clk); check("vec_grant", 128'(req_ready), 128'(4'b0001 << id));
            tick(); req_valid = '0;
            got = 0;
            for (int c = 0; c < 8 && got == 0; c++) begin
                @(negedge clk);
                if (rsp_valid) got = 1; else tick();
            end
            check("vec_valid", 128'(got), 128'd1);
            check("vec_data",  rsp_data, vecs[t].sq);
            check("vec_id",    128'(rsp_id), 128'(vecs[t].id));
            tick();
        end

        // Four simultaneous requests, then a wrap check with 0 and 3
        do_reset();
        for (int i = 0; i < 4; i++) req_data[i*64 +: 64] = 64'(i + 1);
        req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 4) check("four_grant", 128'(req_ready), 128'(4'b0001 << c));
            if (c >= 2) begin
                check("four_valid", 128'(rsp_valid), 128'd1);
                check("four_data",  rsp_data, 128'((c - 1) * (c - 1)));
                check("four_id",    128'(rsp_id), 128'(c - 2));
            end
            tick();
            if (c < 4) req_valid[c] = 1'b0;
        end
        req_data[0 +: 64] = 64'd5; req_data[3*64 +: 64] = 64'd6; req_valid = 4'b1001;
        @(negedge clk); check("wrap_first", 128'(req_ready), 128'(4'b0001));
        tick(); req_valid[0] = 1'b0;
        @(negedge clk); check("wrap_second", 128'(req_ready), 128'(4'b1000));
        tick(); req_valid[3] = 1'b0;
        @(negedge clk);
        check("wrap_rsp0_data", rsp_data, 128'd25);
        check("wrap_rsp0_id",   128'(rsp_id), 128'd0);
        tick();
        @(negedge clk);
        check("wrap_rsp1_data", rsp_data, 128'd36);
        check("wrap_rsp1_id",   128'(rsp_id), 128'd3);
        tick();

        // Backpressure: two requesters active, consumer stalled for 5 cycles
        exp_q.delete();
        rsp_ready = 1'b0;
        req_data[0 +: 64] = 64'd7; req_data[64 +: 64] = 64'd9; req_valid = 4'b0011;
        acc = 0; held = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            g = req_valid & req_ready;
            id = oh2id(g);
            if (g != '0) begin
                exp_q.push_back({IDW'(id), sq64(req_data[id*64 +: 64])});
                acc++;
            end
            if (c >= 2) check("bp_ready_zero", 128'(req_ready), 128'd0);
            if (c == 2) begin
                check("bp_valid", 128'(rsp_valid), 128'd1);
                if (exp_q.size() > 0) check("bp_head", rsp_data, exp_q[0][127:0]);
                held = rsp_data;
            end
            if (c > 2) check("bp_stable", rsp_data, held);
            tick();
            if (g != '0) req_data[id*64 +: 64] = req_data[id*64 +: 64] + 64'd100;
        end
        check("bp_accept_count", 128'(acc), 128'd2);
        req_valid = '0; rsp_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("bp_release_valid", 128'(rsp_valid), 128'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("bp_release_data", rsp_data, e[127:0]);
                check("bp_release_id",   128'(rsp_id), 128'(e[W-1:128]));
            end
            tick();
        end
        @(negedge clk); check("bp_drained_busy", 128'(busy), 128'd0);
        tick();

        // Reset mid-operation with both stages full
        rsp_ready = 1'b0;
        req_data[64 +: 64] = 64'd21; req_data[128 +: 64] = 64'd22; req_valid = 4'b0110;
        tick(); tick();
        @(negedge clk);
        check("rst_pre_busy",  128'(busy), 128'd1);
        check("rst_pre_full",  128'(req_ready), 128'd0);
        tick();
        rst = 1'b1; rsp_ready = 1'b1;   // a handshake would occur here without reset
        tick();
        rst = 1'b0; req_valid = '0;
        @(negedge clk);
        check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        check("rst_busy",      128'(busy), 128'd0);
        check("rst_rsp_data",  rsp_data, 128'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk); check("rst_no_stale", 128'(rsp_valid), 128'd0);
        end
        tick();
        req_valid = 4'b1111;
        @(negedge clk); check("rst_next_grant", 128'(req_ready), 128'(4'b0001));
        tick(); req_valid = '0;
        repeat (3) tick();

        // Requesters 1 and 3 continuously valid
        do_reset();
        req_data[64 +: 64] = 64'd2; req_data[192 +: 64] = 64'd3; req_valid = 4'b1010;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
`ifdef SQUARE_ARB_RR_EN
            exp_g = (c % 2 == 0) ? 4'b0010 : 4'b1000;
`else
            exp_g = 4'b0010;
`endif
            check("pair_grant", 128'(req_ready), 128'(exp_g));
            tick();
        end
        req_valid = '0;
        repeat (3) tick();

        // Randomized phase against the in-order two-entry model
        do_reset();
        exp_q.delete(); edge_q.delete();
        m_last = NREQ - 1;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = ($urandom_range(0, 2) != 0);
                case ($urandom_range(0, 5))
                    0:       op = 64'd0;
                    1:       op = '1;
                    default: op = {$urandom, $urandom};
                endcase
                req_data[i*64 +: 64] = op;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n = exp_q.size();
            // Two results may be in flight. A third is accepted only when
            // the oldest one leaves in the same cycle.
            exp_free = (n < 2) || rsp_ready;
            g = exp_free ? pick(req_valid, m_last) : '0;
            check("rnd_req_ready", 128'(req_ready), 128'(g));
            exp_rv = 1'b0;
            if (n > 0) exp_rv = (edge_q[0] < cycle);
            check("rnd_rsp_valid", 128'(rsp_valid), 128'(exp_rv));
            check("rnd_busy", 128'(busy), 128'(n > 0));
            if (exp_rv) begin
                check("rnd_rsp_data", rsp_data, exp_q[0][127:0]);
                check("rnd_rsp_id",   128'(rsp_id), 128'(exp_q[0][W-1:128]));
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    void'(edge_q.pop_front());
                end
            end
            if (g != '0) begin
                id = oh2id(g);
                exp_q.push_back({IDW'(id), sq64(req_data[id*64 +: 64])});
                edge_q.push_back(cycle + 1);
                m_last = id;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/square_64b_arbiter.md
# square_64b_arbiter

Shares one combinational `square_64b` instance among `NREQ` requesters. A round-robin arbiter picks one operand per cycle, and the block pipelines it through an operand register, the squarer, and a result register. The 128-bit result is returned on a single valid/ready response channel, tagged with the requester ID. It sits between the operand producers and the single squarer datapath, so the squarer never needs to be replicated.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, ≥2.
- `IDW`, default 2: ID width; must equal ceil(log2(NREQ)).

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NREQ: per-requester operand valid.
- `req_data` input NREQ*64: operand of requester i at bits [64i+63:64i].
- `req_ready` output NREQ: one-hot (or zero) grant/accept.
- `rsp_valid` output 1: result register holds a result.
- `rsp_ready` input 1: consumer accepts the result.
- `rsp_data` output 128: unsigned square of the granted operand.
- `rsp_id` output IDW: index of the requester that supplied the operand.
- `busy` output 1: either pipeline stage is occupied.

## Operation
- **Stage S1 (operand register):** holds `s1_v`, `s1_op[63:0]` and `s1_id`. Its contents feed `square_64b` combinationally.
- **Stage S2 (result register):** holds `s2_v`, `s2_res[127:0]` and `s2_id`. These drive `rsp_valid`, `rsp_data` and `rsp_id` directly.
- **Pipeline advance:**
  - `s2_load = s1_v & (~s2_v | rsp_ready)`.
  - `s1_free = ~s1_v | s2_load`.
- **Arbitration:** combinational, over the `req_valid` bits.
  - Round robin starts the search at index `last+1` mod NREQ.
  - `grant` is one-hot of the first valid requester found, or zero.
  - `req_ready = grant & {NREQ{s1_free}}`.
  - A handshake on requester i is `req_valid[i] & req_ready[i]`.
- **On a handshake:**
  - S1 captures the operand and i.
  - `last` ← i.
  - `s1_v` ← 1.
- **On `s2_load` with no new handshake:** `s1_v` ← 0.
- **Response side:**
  - On `s2_load`, S2 captures the squarer output and `s1_id`, and sets `s2_v` ← 1.
  - On `rsp_valid & rsp_ready` with no `s2_load`, `s2_v` ← 0.
- **Arithmetic:** `rsp_data` = zero-extended unsigned in², exactly 128 bits. No truncation or rounding.
- **Requester ordering:** the block never drops or reorders results. Responses leave in grant order.
- **No combinational path** from `rsp_ready` to `rsp_data`. `req_ready` does depend combinationally on `rsp_ready` through `s1_free`.

## Timing
- **Reset values:**
  - `s1_v`=0, `s2_v`=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `busy`=0.
  - `last`=NREQ-1, so requester 0 has first priority.
  - Reset overrides any in-flight handshake. Both stages are flushed, and accepted operands are discarded without a response.
- **Latency:** an operand accepted at edge N gives `rsp_valid`=1 after edge N+1, when `rsp_ready` was held high.
- **Throughput:** one result per cycle while `rsp_ready`=1.
- **Backpressure** (`rsp_ready`=0 with `s2_v`=1):
  - S2 holds its value.
  - S1 can fill once, then `req_ready`=0 on all bits.
  - `rsp_data` and `rsp_id` stay stable until accepted.
- **Simultaneous pop and fill:** both S2 and S1 update in the same cycle; no bubble is inserted.
- **Round-robin wrap:** after granting NREQ-1, the search resumes at 0.
- **No handshake:** `last` is unchanged.
- **Requester behaviour:** a requester may drop `req_valid` before it is granted. The block doesn't require it to be held.

## Configuration
- **`SQUARE_ARB_RR_EN` defined:** round-robin arbitration, as described above.
- **`SQUARE_ARB_RR_EN` undefined:** fixed priority, where the lowest asserted index always wins. The `last` register is removed. All other behaviour and timing are identical.

## Test plan
- **Single request:** requester 2 sends 3 while idle.
  - Expect `rsp_data`=9 and `rsp_id`=2 two cycles after acceptance.
  - Expect `busy`=1 in between, then 0.
- **Four simultaneous requests:** operands 1,2,3,4 held valid with `rsp_ready`=1.
  - Grants go 0,1,2,3 on consecutive cycles.
  - Responses are 1,4,9,16 with IDs 0..3 on back-to-back cycles.
  - Re-requesting from 0 and 3 together then grants 0 first, since the pointer wraps.
- **Extremes:** operand 0xFFFFFFFFFFFFFFFF gives 0xFFFFFFFFFFFFFFFE0000000000000001. Operand 0 gives 0.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles with 2 requesters active.
  - Exactly 2 operands are accepted, then `req_ready`=0.
  - `rsp_data` is stable through the stall.
  - On release, both results appear in grant order.
- **Reset mid-operation:** assert `rst` for 1 cycle with S1 and S2 full.
  - The next cycle shows `rsp_valid`=0 and `busy`=0.
  - No stale response ever appears afterwards.
  - The next grant goes to requester 0.
- **Macro off:** with requesters 1 and 3 continuously valid, requester 1 wins every cycle and requester 3 is never granted.
